// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI responder
//
// Purpose: state encoding, flag bit positions and SPI mode constants used by
// spi_slave, spi_sync_edge and anything that reads the flags vector.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  // Bit positions inside the sticky flags vector {abort, tx_underrun, rx_overrun}.
  localparam int FLAG_OVR = 0;
  localparam int FLAG_UDR = 1;
  localparam int FLAG_ABT = 2;

  // Clock polarity: SCK idle level.
  localparam bit CPOL_LOW  = 1'b0;
  localparam bit CPOL_HIGH = 1'b1;

  // Clock phase: which SCK edge samples MOSI.
  localparam bit CPHA_LEAD_SAMPLE  = 1'b0;
  localparam bit CPHA_TRAIL_SAMPLE = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - pin synchronizer and SCK/CS edge detector
//
// Purpose: bring SCK, CS and MOSI into the clk domain and turn them into
// single-cycle edge pulses. All outputs are registered so the pulses and the
// MOSI sample that goes with them line up in the same cycle.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   sck, cs, mosi       raw SPI pins
//   sck_lead/sck_trail  pulse on SCK leaving / returning to its idle level
//   cs_fall/cs_rise     pulse on synchronized CS falling / rising
//   cs_active           synchronized CS is low
//   mosi_s              synchronized MOSI aligned with the edge pulses
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = CPOL_LOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic cs,
  input  logic mosi,
  output logic sck_lead,
  output logic sck_trail,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_active,
  output logic mosi_s
);

  localparam logic SCK_IDLE = (CPOL == CPOL_HIGH);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sck_last_q, sck_last_d;
  logic cs_last_q, cs_last_d;
  logic sck_lead_q, sck_lead_d;
  logic sck_trail_q, sck_trail_d;
  logic cs_fall_q, cs_fall_d;
  logic cs_rise_q, cs_rise_d;
  logic cs_active_q, cs_active_d;
  logic mosi_s_q, mosi_s_d;

  logic sck_s, cs_s;
  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign cs_s  = cs_sync_q[SYNC_STAGES-1];

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_last_d  = sck_s;
    cs_last_d   = cs_s;
    sck_lead_d  = (sck_last_q == SCK_IDLE) && (sck_s != SCK_IDLE);
    sck_trail_d = (sck_last_q != SCK_IDLE) && (sck_s == SCK_IDLE);
    cs_fall_d   = cs_last_q && !cs_s;
    cs_rise_d   = !cs_last_q && cs_s;
    cs_active_d = !cs_s;
    mosi_s_d    = mosi_sync_q[SYNC_STAGES-1];
  end

  // SCK resets to its idle level and CS to inactive so reset release never
  // fabricates an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= {SYNC_STAGES{SCK_IDLE}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_last_q  <= SCK_IDLE;
      cs_last_q   <= 1'b1;
      sck_lead_q  <= 1'b0;
      sck_trail_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_active_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_last_q  <= sck_last_d;
      cs_last_q   <= cs_last_d;
      sck_lead_q  <= sck_lead_d;
      sck_trail_q <= sck_trail_d;
      cs_fall_q   <= cs_fall_d;
      cs_rise_q   <= cs_rise_d;
      cs_active_q <= cs_active_d;
      mosi_s_q    <= mosi_s_d;
    end
  end

  assign sck_lead  = sck_lead_q;
  assign sck_trail = sck_trail_q;
  assign cs_fall   = cs_fall_q;
  assign cs_rise   = cs_rise_q;
  assign cs_active = cs_active_q;
  assign mosi_s    = mosi_s_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI responder with TX/RX word streams
//
// Purpose: full-duplex MSB-first SPI slave clocked by io_apb_PCLK.
// Ports:
//   io_apb_PCLK, io_apb_PRESET     clock, asynchronous active-low reset
//   SPI_SCK/SPI_CS/SPI_MOSI        pins from the master
//   SPI_MISO, SPI_MISO_OE          slave data and pad enable
//   tx_data/tx_valid/tx_ready      TX holding register write port
//   rx_data/rx_valid/rx_ready      received word stream
//   busy                           a transfer is in progress
//   flags/flags_clr                sticky {abort, tx_underrun, rx_overrun}, W1C
//   interrupt                      rx_valid or any flag
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter bit CPOL        = CPOL_LOW,
  parameter bit CPHA        = CPHA_LEAD_SAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  io_apb_PCLK,
  input  logic                  io_apb_PRESET,
  input  logic                  SPI_SCK,
  input  logic                  SPI_CS,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  output logic                  SPI_MISO_OE,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic [2:0]            flags,
  input  logic [2:0]            flags_clr,
  output logic                  interrupt
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic sck_lead, sck_trail, cs_fall, cs_rise, cs_active, mosi_s;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .CPOL       (CPOL)
  ) u_sync (
    .clk      (io_apb_PCLK),
    .rst_n    (io_apb_PRESET),
    .sck      (SPI_SCK),
    .cs       (SPI_CS),
    .mosi     (SPI_MOSI),
    .sck_lead (sck_lead),
    .sck_trail(sck_trail),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .cs_active(cs_active),
    .mosi_s   (mosi_s)
  );

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
  logic                  tx_full_q, tx_full_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q, miso_d;
  logic                  udr_pend_q, udr_pend_d;
  logic [2:0]            flags_q, flags_d;
  logic [2:0]            flag_set;

  logic                  sample_edge, shift_edge, last_bit;
  logic [DATA_WIDTH-1:0] next_word;

  assign sample_edge = (CPHA == CPHA_LEAD_SAMPLE) ? sck_lead : sck_trail;
  assign shift_edge  = (CPHA == CPHA_LEAD_SAMPLE) ? sck_trail : sck_lead;
  assign last_bit    = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign next_word   = tx_full_q ? tx_hold_q : '0;

  always_comb begin
    state_d    = state_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    miso_d     = miso_q;
    udr_pend_d = udr_pend_q;
    flag_set   = '0;

    // A write is only accepted while empty, so it never collides with a
    // load below (which only clears tx_full when it was set).
    if (tx_valid && !tx_full_q) begin
      tx_hold_d = tx_data;
      tx_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          udr_pend_d = 1'b0;
          if (tx_full_q) tx_full_d = 1'b0;
          else           flag_set[FLAG_UDR] = 1'b1;
          // tx_shift holds the bits not yet driven; with CPHA=0 the MSB goes
          // out right away, so it is removed from the shifter here.
          if (CPHA == CPHA_LEAD_SAMPLE) begin
            miso_d     = next_word[DATA_WIDTH-1];
            tx_shift_d = {next_word[DATA_WIDTH-2:0], 1'b0};
          end else begin
            tx_shift_d = next_word;
          end
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d    = IDLE;
          miso_d     = 1'b0;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          udr_pend_d = 1'b0;
          flag_set[FLAG_ABT] = (bit_cnt_q != '0);
        end else begin
          if (shift_edge) begin
            miso_d     = tx_shift_q[DATA_WIDTH-1];
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            // A word-boundary reload from an empty holding register only
            // counts as an underrun once the master actually clocks that word.
            if (bit_cnt_q == '0 && udr_pend_q) begin
              flag_set[FLAG_UDR] = 1'b1;
              udr_pend_d         = 1'b0;
            end
            if (last_bit) begin
              bit_cnt_d  = '0;
              rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
              rx_valid_d = 1'b1;
              if (rx_valid_q && !rx_ready) flag_set[FLAG_OVR] = 1'b1;
              tx_shift_d = next_word;
              if (tx_full_q) tx_full_d = 1'b0;
              else           udr_pend_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Set beats clear when both hit the same flag in one cycle.
    flags_d = (flags_q & ~flags_clr) | flag_set;
  end

  always_ff @(posedge io_apb_PCLK or negedge io_apb_PRESET) begin
    if (!io_apb_PRESET) begin
      state_q    <= IDLE;
      tx_hold_q  <= '0;
      tx_full_q  <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      udr_pend_q <= 1'b0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      udr_pend_q <= udr_pend_d;
      flags_q    <= flags_d;
    end
  end

  assign SPI_MISO_OE = cs_active && (state_q == SHIFT);
  assign SPI_MISO    = miso_q && SPI_MISO_OE;
  assign tx_ready    = !tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q == SHIFT);
  assign flags       = flags_q;
  assign interrupt   = rx_valid_q || (|flags_q);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: mode 0. Instance B: mode 3.
  logic       cs_a = 1'b1, sck_a = 1'b0, mosi_a = 1'b0;
  logic       miso_a, oe_a, tx_ready_a, rx_valid_a, busy_a, irq_a;
  logic [7:0] tx_data_a = '0, rx_data_a;
  logic       tx_valid_a = 1'b0, rx_ready_a = 1'b0;
  logic [2:0] flags_a, flags_clr_a = '0;

  logic       cs_b = 1'b1, sck_b = 1'b1, mosi_b = 1'b0;
  logic       miso_b, oe_b, tx_ready_b, rx_valid_b, busy_b, irq_b;
  logic [7:0] tx_data_b = '0, rx_data_b;
  logic       tx_valid_b = 1'b0, rx_ready_b = 1'b0;
  logic [2:0] flags_b, flags_clr_b = '0;

  spi_slave #(.DATA_WIDTH(8), .CPOL(CPOL_LOW), .CPHA(CPHA_LEAD_SAMPLE), .SYNC_STAGES(2)) u_a (
    .io_apb_PCLK(clk), .io_apb_PRESET(rst_n),
    .SPI_SCK(sck_a), .SPI_CS(cs_a), .SPI_MOSI(mosi_a),
    .SPI_MISO(miso_a), .SPI_MISO_OE(oe_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .busy(busy_a), .flags(flags_a), .flags_clr(flags_clr_a), .interrupt(irq_a)
  );

  spi_slave #(.DATA_WIDTH(8), .CPOL(CPOL_HIGH), .CPHA(CPHA_TRAIL_SAMPLE), .SYNC_STAGES(2)) u_b (
    .io_apb_PCLK(clk), .io_apb_PRESET(rst_n),
    .SPI_SCK(sck_b), .SPI_CS(cs_b), .SPI_MOSI(mosi_b),
    .SPI_MISO(miso_b), .SPI_MISO_OE(oe_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .busy(busy_b), .flags(flags_b), .flags_clr(flags_clr_b), .interrupt(irq_b)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(input logic [7:0] d);
    tx_data_a = d; tx_valid_a = 1'b1; tick(1); tx_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    tx_data_b = d; tx_valid_b = 1'b1; tick(1); tx_valid_b = 1'b0;
  endtask

  // Mode 0 master: returns right after the last rising SCK (SCK left high).
  task automatic xfer_a(input logic [7:0] mo, output logic [7:0] mi, input int nbits);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      sck_a = 1'b0; mosi_a = mo[7-i];
      tick(6);
      mi[7-i] = miso_a;
      sck_a = 1'b1;
      if (i < nbits - 1) tick(6);
    end
  endtask

  // Mode 3 master: shift on falling, sample on rising, SCK ends idle high.
  task automatic xfer_b(input logic [7:0] mo, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < 8; i++) begin
      sck_b = 1'b0; mosi_b = mo[7-i];
      tick(6);
      mi[7-i] = miso_b;
      sck_b = 1'b1;
      tick(6);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_miso"}, miso_a, 1'b0);
    check({tag, "_oe"}, oe_a, 1'b0);
    check({tag, "_tx_ready"}, tx_ready_a, 1'b1);
    check({tag, "_rx_valid"}, rx_valid_a, 1'b0);
    check({tag, "_rx_data"}, rx_data_a, 8'h00);
    check({tag, "_busy"}, busy_a, 1'b0);
    check({tag, "_flags"}, flags_a, 3'b000);
    check({tag, "_irq"}, irq_a, 1'b0);
  endtask

  logic [7:0] mi;

  initial begin
    // Reset
    tick(3);
    check_reset_a("rst");
    check("rst_b_tx_ready", tx_ready_b, 1'b1);
    check("rst_b_oe", oe_b, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Mode 0: tx 0xA5, rx 0x3C, latency 4 PCLK after 8th rising SCK
    push_a(8'hA5);
    check("t1_tx_ready_low", tx_ready_a, 1'b0);
    cs_a = 1'b0; tick(6);
    check("t1_busy", busy_a, 1'b1);
    check("t1_oe", oe_a, 1'b1);
    check("t1_tx_ready_load", tx_ready_a, 1'b1);
    xfer_a(8'h3C, mi, 8);
    tick(3);
    check("t1_rx_valid_early", rx_valid_a, 1'b0);
    tick(1);
    check("t1_rx_valid", rx_valid_a, 1'b1);
    check("t1_rx_data", rx_data_a, 8'h3C);
    check("t1_miso", mi, 8'hA5);
    tick(6); sck_a = 1'b0; tick(6);
    cs_a = 1'b1; tick(6);
    check("t1_busy_end", busy_a, 1'b0);
    check("t1_flags", flags_a, 3'b000);
    rx_ready_a = 1'b1; tick(1); rx_ready_a = 1'b0;
    check("t1_rx_drained", rx_valid_a, 1'b0);

    // Mode 3: back-to-back words under one CS
    push_b(8'h12);
    cs_b = 1'b0; tick(6);
    push_b(8'h34);
    check("t2_tx_ready_low", tx_ready_b, 1'b0);
    xfer_b(8'hF0, mi);
    check("t2_miso0", mi, 8'h12);
    check("t2_rx_valid0", rx_valid_b, 1'b1);
    check("t2_rx_data0", rx_data_b, 8'hF0);
    check("t2_tx_ready_reload", tx_ready_b, 1'b1);
    rx_ready_b = 1'b1; tick(1); rx_ready_b = 1'b0;
    xfer_b(8'h0F, mi);
    check("t2_miso1", mi, 8'h34);
    check("t2_rx_data1", rx_data_b, 8'h0F);
    cs_b = 1'b1; tick(6);
    check("t2_flags", flags_b, 3'b000);
    check("t2_busy_end", busy_b, 1'b0);

    // Underrun on empty holding register
    cs_a = 1'b0; tick(6);
    check("t3_flags_udr", flags_a, 3'b010);
    check("t3_irq", irq_a, 1'b1);
    xfer_a(8'h55, mi, 8);
    tick(6);
    check("t3_miso_zero", mi, 8'h00);
    check("t3_rx_data", rx_data_a, 8'h55);
    sck_a = 1'b0; tick(6);
    cs_a = 1'b1; tick(6);
    flags_clr_a = 3'b010; tick(1); flags_clr_a = 3'b000;
    check("t3_flags_clr", flags_a, 3'b000);
    rx_ready_a = 1'b1; tick(1); rx_ready_a = 1'b0;

    // Overrun, then handshake coincident with completion
    push_a(8'h81);
    cs_a = 1'b0; tick(6);
    push_a(8'h42);
    xfer_a(8'h11, mi, 8);
    check("t4_miso0", mi, 8'h81);
    tick(6);
    xfer_a(8'h22, mi, 8);
    check("t4_miso1", mi, 8'h42);
    tick(6);
    check("t4_rx_data", rx_data_a, 8'h22);
    check("t4_rx_valid", rx_valid_a, 1'b1);
    check("t4_flags_ovr", flags_a, 3'b001);
    flags_clr_a = 3'b001; tick(1); flags_clr_a = 3'b000;
    xfer_a(8'h33, mi, 8);
    tick(3);
    rx_ready_a = 1'b1; tick(1); rx_ready_a = 1'b0;
    check("t4_rx_valid_hs", rx_valid_a, 1'b1);
    check("t4_rx_data_hs", rx_data_a, 8'h33);
    check("t4_flags_no_ovr", flags_a, 3'b010);
    tick(6); sck_a = 1'b0; tick(6);
    cs_a = 1'b1; tick(6);
    flags_clr_a = 3'b111; rx_ready_a = 1'b1; tick(1);
    flags_clr_a = 3'b000; rx_ready_a = 1'b0;
    check("t4_cleanup", {rx_valid_a, flags_a}, 4'b0000);

    // Abort after 3 bits, then a normal transfer
    push_a(8'h96);
    cs_a = 1'b0; tick(6);
    xfer_a(8'hFF, mi, 3);
    tick(6); sck_a = 1'b0; tick(6);
    cs_a = 1'b1; tick(6);
    check("t5_busy", busy_a, 1'b0);
    check("t5_rx_valid", rx_valid_a, 1'b0);
    check("t5_flags_abt", flags_a, 3'b100);
    check("t5_tx_ready", tx_ready_a, 1'b1);
    flags_clr_a = 3'b100; tick(1); flags_clr_a = 3'b000;
    push_a(8'h5A);
    cs_a = 1'b0; tick(6);
    xfer_a(8'hC3, mi, 8);
    tick(6);
    check("t5_next_rx", rx_data_a, 8'hC3);
    check("t5_next_miso", mi, 8'h5A);
    check("t5_next_flags", flags_a, 3'b000);
    sck_a = 1'b0; tick(6);
    cs_a = 1'b1; tick(6);
    rx_ready_a = 1'b1; tick(1); rx_ready_a = 1'b0;

    // Reset during bit 5
    push_a(8'h77);
    cs_a = 1'b0; tick(6);
    xfer_a(8'hAA, mi, 5);
    tick(2);
    check("t6_busy_pre", busy_a, 1'b1);
    check("t6_oe_pre", oe_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_oe_async", oe_a, 1'b0);
    check("t6_miso_async", miso_a, 1'b0);
    check("t6_busy_async", busy_a, 1'b0);
    cs_a = 1'b1; sck_a = 1'b0;
    tick(2);
    check_reset_a("t6");
    rst_n = 1'b1;
    tick(2);
    check("t6_post_tx_ready", tx_ready_a, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
